ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, successor to the single-byte receiver. Synchronises and glitch-filters `ps2_clk`/`ps2_data`, decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and checks framing and inter-edge timeout. Good bytes go into an internal first-word-fall-through FIFO that the keyboard/mouse decoder drains.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_fifo.sv | 70 +++++++
 rtl/ps2_rx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame width and default timing
// constants, used by the receiver and the future host-to-device transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS     = 8;
    localparam int PS2_TIMEOUT_TICKS = 12500;
    localparam int PS2_FILT_LEN      = 8;

    // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO. The head byte is held in a register that is
// reloaded from the array (or forwarded from a write into an empty slot).
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_fire, wr_fire;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign rd_data = rd_data_reg;

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign rd_fire = rd_en && valid;
    assign wr_fire = wr_en && (!full || rd_fire);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(rd_fire);
        count_next  = count_reg;
        if (wr_fire && !rd_fire) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (!wr_fire && rd_fire) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(wr_fire);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // The new head is the entry being written this cycle when it lands at the read slot.
            if (count_next == '0) begin
                rd_data_reg <= '0;
            end else if (wr_fire && (wr_ptr_reg == rd_ptr_next)) begin
                rd_data_reg <= wr_data;
            end else begin
                rd_data_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, frame checks, timeout and FWFT FIFO.
// Define PS2_RX_PARITY_EN to enable the odd-parity check; otherwise parity is consumed and ignored.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILT_LEN      = PS2_FILT_LEN,
    parameter int TIMEOUT_TICKS = PS2_TIMEOUT_TICKS,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       full,
    output logic       overflow,
    output logic       frame_err,
    output logic       parity_err,
    output logic       timeout
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_TICKS);
    localparam int BCW = $clog2(PS2_DATA_BITS);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_TICKS - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(PS2_DATA_BITS - 1);

    logic [1:0]               clk_sync_reg, data_sync_reg;
    logic                     clk_s, data_s;
    logic                     filt_reg;
    logic [FCW-1:0]           filt_cnt_reg;
    logic                     flip, fall;
    ps2_state_t               state_reg, state_next;
    logic [BCW-1:0]           bit_cnt_reg;
    logic [PS2_DATA_BITS-1:0] sr_reg;
    logic [TCW-1:0]           to_cnt_reg;
    logic                     to_expire, parity_bad, push;
    logic                     frame_err_next, parity_err_next, overflow_next;
    logic                     frame_err_reg, parity_err_reg, overflow_reg, timeout_reg;

    // Idle PS/2 lines are pulled high, so the synchronisers reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    assign flip = (clk_s != filt_reg) && (filt_cnt_reg == FILT_LAST);
    assign fall = flip && filt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_reg     <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_s == filt_reg) begin
            filt_cnt_reg <= '0;
        end else if (flip) begin
            filt_reg     <= clk_s;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + FCW'(1);
        end
    end

    assign to_expire = (state_reg != ST_IDLE) && !fall && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (to_expire) begin
            state_next = ST_IDLE;
        end else if (fall) begin
            case (state_reg)
                ST_IDLE:   if (!data_s) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt_reg == BIT_LAST) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

`ifdef PS2_RX_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (fall && (state_reg == ST_PARITY)) begin
            parity_reg <= data_s;
        end
    end

    assign parity_bad = !odd_parity_ok(sr_reg, parity_reg);
`else
    assign parity_bad = 1'b0;
`endif

    // Stop-bit evaluation: bad stop wins over bad parity; only clean frames are pushed.
    always_comb begin
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        push            = 1'b0;
        if (fall && (state_reg == ST_IDLE) && data_s) begin
            frame_err_next = 1'b1;
        end else if (fall && (state_reg == ST_STOP)) begin
            if (!data_s) begin
                frame_err_next = 1'b1;
            end else if (parity_bad) begin
                parity_err_next = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
        overflow_next = push && full && !(rd_en && valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg    <= '0;
            sr_reg         <= '0;
            to_cnt_reg     <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            overflow_reg   <= overflow_next;
            timeout_reg    <= to_expire;
            if ((state_reg == ST_IDLE) || fall || to_expire) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + TCW'(1);
            end
            if (fall && (state_reg == ST_IDLE)) begin
                bit_cnt_reg <= '0;
            end else if (fall && (state_reg == ST_DATA)) begin
                sr_reg      <= {data_s, sr_reg[PS2_DATA_BITS-1:1]};
                bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            end
        end
    end

    assign frame_err  = frame_err_reg;
    assign overflow   = overflow_reg;
    assign timeout    = timeout_reg;
`ifdef PS2_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    ps2_sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (sr_reg),
        .rd_en   (rd_en),
        .rd_data (data),
        .valid   (valid),
        .full    (full)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: shortened PS/2 bit timing, hand-computed
// frames and expected bytes, pulse counting for error/overflow outputs.
module tb_ps2_rx_fifo;

    localparam int FILT  = 8;
    localparam int TO    = 400;
    localparam int DEPTH = 4;
    localparam int HALF  = 100;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, rd_en;
    logic [7:0] data;
    logic       valid, full, overflow, frame_err, parity_err, timeout;

    int checks = 0;
    int errors = 0;
    int n_ovf = 0, n_fe = 0, n_pe = 0, n_to = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILT_LEN      (FILT),
        .TIMEOUT_TICKS (TO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .data       (data),
        .valid      (valid),
        .full       (full),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .timeout    (timeout)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (overflow)   n_ovf++;
            if (frame_err)  n_fe++;
            if (parity_err) n_pe++;
            if (timeout)    n_to++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // {stop, parity, data[7:0], start}; the parity bit is odd parity unless par_good=0.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic par_good, input logic stop);
        logic p;
        p = ~^b;
        if (!par_good) p = ~p;
        return {stop, p, b, 1'b0};
    endfunction

    // glitch 1: 3-cycle low pulse while clock high; 2: 3-cycle high pulse while clock low
    task automatic send_bit(input logic b, input int glitch);
        ps2_data = b;
        wait_cyc(HALF / 2);
        if (glitch == 1) begin
            ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1;
        end
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(HALF / 2);
        if (glitch == 2) begin
            ps2_clk = 1'b1; wait_cyc(3); ps2_clk = 1'b0;
        end
        wait_cyc(HALF / 2);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int gbit, input int gkind);
        for (int i = 0; i < 11; i++) send_bit(f[i], (i == gbit) ? gkind : 0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        $display("frame sent bits=%011b byte=%02h valid=%0b data=%02h full=%0b", f, f[8:1], valid, data, full);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        wait_cyc(3);
        checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data got=%02h exp=00", data); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_basic();
        send_frame(frame(8'hEE, 1'b1, 1'b1), -1, 0);
        checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL basic_valid got=%b exp=1", valid); end
        checks++; if (data !== 8'hEE)  begin errors++; $display("FAIL basic_data got=%02h exp=ee", data); end
        checks++; if (n_fe + n_pe + n_to + n_ovf !== 0) begin errors++; $display("FAIL basic_no_errors got=%0d exp=0", n_fe + n_pe + n_to + n_ovf); end
        pop();
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL basic_pop_valid got=%b exp=0", valid); end
    endtask

    task automatic test_timeout();
        int t0, f0;
        t0 = n_to; f0 = n_fe;
        send_bit(1'b0, 0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(TO + 100);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        $display("partial frame: start + one bit, clock held low %0d cycles", TO + 100);
        checks++; if (n_to - t0 !== 1) begin errors++; $display("FAIL timeout_pulses got=%0d exp=1", n_to - t0); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL timeout_no_push got=%b exp=0", valid); end
        checks++; if (n_fe - f0 !== 0) begin errors++; $display("FAIL timeout_frame_err got=%0d exp=0", n_fe - f0); end
        send_frame(frame(8'hEE, 1'b1, 1'b1), -1, 0);
        checks++; if (data !== 8'hEE || valid !== 1'b1) begin errors++; $display("FAIL timeout_recover got=%02h/%b exp=ee/1", data, valid); end
        pop();
    endtask

    task automatic test_parity();
        int p0;
        p0 = n_pe;
        send_frame(frame(8'hEE, 1'b0, 1'b1), -1, 0);
`ifdef PS2_RX_PARITY_EN
        checks++; if (n_pe - p0 !== 1) begin errors++; $display("FAIL parity_err_pulses got=%0d exp=1", n_pe - p0); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL parity_no_push got=%b exp=0", valid); end
`else
        checks++; if (n_pe - p0 !== 0) begin errors++; $display("FAIL parity_err_pulses got=%0d exp=0", n_pe - p0); end
        checks++; if (data !== 8'hEE || valid !== 1'b1) begin errors++; $display("FAIL parity_ignored got=%02h/%b exp=ee/1", data, valid); end
        pop();
`endif
    endtask

    task automatic test_framing();
        int f0;
        f0 = n_fe;
        send_frame(frame(8'hEE, 1'b1, 1'b0), -1, 0);
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL stop0_pulses got=%0d exp=1", n_fe - f0); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL stop0_no_push got=%b exp=0", valid); end
        f0 = n_fe;
        send_bit(1'b1, 0);
        wait_cyc(HALF);
        $display("lone start bit of 1 sent");
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL start1_pulses got=%0d exp=1", n_fe - f0); end
        send_frame(frame(8'h5A, 1'b1, 1'b1), -1, 0);
        checks++; if (data !== 8'h5A || valid !== 1'b1) begin errors++; $display("FAIL start1_idle got=%02h/%b exp=5a/1", data, valid); end
        checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL start1_realign got=%0d exp=1", n_fe - f0); end
        pop();
    endtask

    task automatic test_overflow();
        int o0;
        o0 = n_ovf;
        for (int b = 1; b <= 5; b++) begin
            send_frame(frame(8'(b), 1'b1, 1'b1), -1, 0);
            if (b == 3) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_not_full3 got=%b exp=0", full); end
            end
            if (b == 4) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4 got=%b exp=1", full); end
                checks++; if (n_ovf - o0 !== 0) begin errors++; $display("FAIL ovf_none4 got=%0d exp=0", n_ovf - o0); end
            end
        end
        checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulse5 got=%0d exp=1", n_ovf - o0); end
        checks++; if (full !== 1'b1)    begin errors++; $display("FAIL ovf_full5 got=%b exp=1", full); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (valid !== 1'b1 || data !== 8'(k)) begin errors++; $display("FAIL ovf_read%0d got=%02h/%b exp=%02h/1", k, data, valid, k); end
            $display("read byte %02h", data);
            pop();
        end
        checks++; if (valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b/%b exp=0/0", valid, full); end
    endtask

    task automatic test_glitch();
        send_frame(frame(8'hA5, 1'b1, 1'b1), 3, 1);
        checks++; if (data !== 8'hA5 || valid !== 1'b1) begin errors++; $display("FAIL glitch_high got=%02h/%b exp=a5/1", data, valid); end
        pop();
        send_frame(frame(8'h96, 1'b1, 1'b1), 6, 2);
        checks++; if (data !== 8'h96 || valid !== 1'b1) begin errors++; $display("FAIL glitch_low got=%02h/%b exp=96/1", data, valid); end
        pop();
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        send_frame(frame(8'h11, 1'b1, 1'b1), -1, 0);
        f = frame(8'h22, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(f[i], 0);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(HALF);
        $display("reset pulsed mid-frame valid=%0b data=%02h", valid, data);
        checks++; if (valid !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL rstmid_empty got=%02h/%b exp=00/0", data, valid); end
        send_frame(frame(8'h3C, 1'b1, 1'b1), -1, 0);
        checks++; if (data !== 8'h3C || valid !== 1'b1) begin errors++; $display("FAIL rstmid_next got=%02h/%b exp=3c/1", data, valid); end
        pop();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_pop got=%b exp=0", valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_parity();
        test_framing();
        test_overflow();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
